gcd_control: RTL
================

// Module: gcd_control
// PURPOSE
//  Sequencing FSM for the subtractive GCD datapath (gcd_circuit).
//  - On start: loads X/Y, then issues one subtraction per cycle until X==Y.
//  - Then asserts output_en so the datapath drives the result on out, and pulses done.
//  - Sits beside gcd_circuit inside gcd_top; consumes its x_lt_y/x_ne_y status and drives all selects/enables.
// PARAMETERS
//  CNT_W    16   width of iteration counter iter_count
//  MAX_ITER 1000 subtraction limit before error (used only with GCD_CTRL_TIMEOUT_EN); must be < 2**CNT_W
// PORTS
//  clock      in   1      single clock, all state on rising edge
//  reset      in   1      asynchronous, active-low; clears all state immediately
//  start      in   1      request; sampled only in IDLE
//  x_lt_y     in   1      datapath: X < Y (from registered X/Y)
//  x_ne_y     in   1      datapath: X != Y
//  x_sel      out  1      0: X reg loads input X; 1: loads X-Y
//  y_sel      out  1      0: Y reg loads input Y; 1: loads Y-X
//  x_en       out  1      X register write enable
//  y_en       out  1      Y register write enable
//  output_en  out  1      datapath drives X onto out
//  busy       out  1      high in every state except IDLE
//  done       out  1      one-cycle completion pulse
//  error      out  1      one-cycle timeout pulse (with done)
//  iter_count out  CNT_W  subtractions issued in current/last run
// BEHAVIOUR
//  - Reset (reset==0): state=IDLE; all 1-bit outputs 0; iter_count=0. Asserting mid-run aborts with no done.
//  - States: IDLE, LOAD, ITER, DONE, ERR.
//  - IDLE: all enables 0. start==1 -> LOAD. Otherwise stay.
//  - LOAD: x_en=y_en=1, x_sel=y_sel=0; iter_count<=0. -> ITER.
//  - ITER: Mealy outputs from x_ne_y/x_lt_y of same cycle.
//    - x_ne_y==0: no enables -> DONE.
//    - x_lt_y==1: y_en=1, y_sel=1, stay.
//    - else: x_en=1, x_sel=1, stay.
//    - iter_count +1 per subtraction cycle; saturates at all-ones.
//  - DONE: output_en=1, done=1 for exactly one cycle -> IDLE. iter_count holds until next LOAD.
//  - Never x_en and y_en together except in LOAD.
//  - start ignored while busy, including held high. Rising start is not required: high in IDLE starts a new run.
//  - Timing: start high in cycle 0 -> LOAD in cycle 1. With S subtractions -> ITER in cycles 2..2+S, DONE in cycle 3+S.
//  - Zero operand: subtraction never converges (e.g. 0/5); see CONFIGURATION.
// CONFIGURATION
//  GCD_CTRL_TIMEOUT_EN defined:
//   - In ITER, if x_ne_y==1 and iter_count==MAX_ITER, no enables -> ERR.
//   - ERR: error=1, done=1, output_en=0 for one cycle -> IDLE.
//  GCD_CTRL_TIMEOUT_EN undefined:
//   - ERR state absent; error tied 0; ITER runs until X==Y or reset.
// STRUCTURE
//  - gcd_ctrl_pkg: state encoding localparams (IDLE=0, LOAD=1, ITER=2, DONE=3, ERR=4, 3-bit) and sel codes SEL_LOAD=0, SEL_SUB=1.
//  - Sub-module gcd_iter_counter: CNT_W saturating counter with clear/inc.
//  - FSM plus output decode stay in gcd_control.
// TESTING (bench: gcd_control + gcd_circuit)
//  1. 354/118, start 1 cycle -> 2 subtractions (X 236, 118). DONE in cycle 5; out=118; iter_count=2; done 1 cycle.
//  2. 9/6 -> X=3, then Y=3; iter_count=2; out=3; y_en/y_sel seen exactly once.
//  3. 7/7 -> no subtraction; DONE in cycle 3; out=7; iter_count=0.
//  4. start held high through run with 9/6 -> one done, then immediate new run next IDLE; start pulsed mid-ITER -> ignored.
//  5. reset low during ITER of 354/118 -> all outputs 0 same cycle (async); no done; next start runs clean.
//  6. TIMEOUT_EN, MAX_ITER=8, X=0 Y=5 -> 8 y-subtractions, then error=done=1 one cycle, output_en stays 0. Without macro: busy stays high for 100 cycles.

Source files
------------

// File: rtl/gcd_ctrl_pkg.sv
// Shared encodings for the subtractive-GCD sequencer: state codes and datapath mux select codes.
// The ERR code is reserved even when the timeout feature (GCD_CTRL_TIMEOUT_EN) is compiled out.
package gcd_ctrl_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] ENC_IDLE = 3'd0;
  localparam logic [STATE_W-1:0] ENC_LOAD = 3'd1;
  localparam logic [STATE_W-1:0] ENC_ITER = 3'd2;
  localparam logic [STATE_W-1:0] ENC_DONE = 3'd3;
  localparam logic [STATE_W-1:0] ENC_ERR  = 3'd4;

  typedef enum logic [STATE_W-1:0] {
    IDLE = ENC_IDLE,
    LOAD = ENC_LOAD,
    ITER = ENC_ITER,
    DONE = ENC_DONE,
    ERR  = ENC_ERR
  } state_t;

  // Register input mux: load external operand vs. load the difference.
  localparam logic SEL_LOAD = 1'b0;
  localparam logic SEL_SUB  = 1'b1;

  function automatic logic is_busy(input state_t s);
    return (s != IDLE);
  endfunction

endpackage

// File: rtl/gcd_iter_counter.sv
// Saturating iteration counter: synchronous clear has priority over increment; sticks at all-ones.
module gcd_iter_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;

  always_comb begin
    count_next = count_reg;
    if (clear) begin
      count_next = '0;
    end else if (inc && (count_reg != '1)) begin
      count_next = count_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/gcd_control.sv
// Sequencer for the subtractive GCD datapath: load operands, subtract until equal, present result.
// Define GCD_CTRL_TIMEOUT_EN to abort with error after MAX_ITER subtractions.
module gcd_control
  import gcd_ctrl_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int MAX_ITER = 1000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             x_lt_y,
  input  logic             x_ne_y,
  output logic             x_sel,
  output logic             y_sel,
  output logic             x_en,
  output logic             y_en,
  output logic             output_en,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] iter_count
);

  state_t state_reg;
  state_t state_next;

  logic cnt_clear;
  logic cnt_inc;
  logic timeout_hit;

  assign timeout_hit = (iter_count == CNT_W'(MAX_ITER));

`ifndef GCD_CTRL_TIMEOUT_EN
  logic unused_timeout;
  assign unused_timeout = timeout_hit;
`endif

  gcd_iter_counter #(
    .CNT_W (CNT_W)
  ) u_iter_counter (
    .clock (clock),
    .reset (reset),
    .clear (cnt_clear),
    .inc   (cnt_inc),
    .count (iter_count)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Outputs are decoded from the current state so an async reset silences them immediately.
  always_comb begin
    state_next = state_reg;
    x_sel      = SEL_LOAD;
    y_sel      = SEL_LOAD;
    x_en       = 1'b0;
    y_en       = 1'b0;
    output_en  = 1'b0;
    done       = 1'b0;
    error      = 1'b0;
    cnt_clear  = 1'b0;
    cnt_inc    = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = LOAD;
        end
      end

      LOAD: begin
        x_en       = 1'b1;
        y_en       = 1'b1;
        cnt_clear  = 1'b1;
        state_next = ITER;
      end

      ITER: begin
        if (!x_ne_y) begin
          state_next = DONE;
`ifdef GCD_CTRL_TIMEOUT_EN
        end else if (timeout_hit) begin
          state_next = ERR;
`endif
        end else if (x_lt_y) begin
          y_en    = 1'b1;
          y_sel   = SEL_SUB;
          cnt_inc = 1'b1;
        end else begin
          x_en    = 1'b1;
          x_sel   = SEL_SUB;
          cnt_inc = 1'b1;
        end
      end

      DONE: begin
        output_en  = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end

`ifdef GCD_CTRL_TIMEOUT_EN
      ERR: begin
        error      = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
`endif

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign busy = is_busy(state_reg);

endmodule
